// File: rtl/ps2_action_mapper.sv
// ps2_action_mapper
//   Turns the PS/2 set-2 scan-code byte stream into ship control actions.
//   A small decoder FSM handles the E0 (extended) and F0 (break) prefixes
//   and maintains a table of held keys. Action outputs are derived from that
//   table according to the binding mode, with opposing-key cancellation,
//   edge-detected shoot/start pulses and shoot auto-fire.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   byte_data[7:0]  : received scan-code byte
//   byte_valid      : one-cycle strobe qualifying byte_data
//   mode[1:0]       : 00 arrows, 01 WASD, 10/11 both OR-ed
//   forward, backward, rotate_left, rotate_right : registered action levels
//   shoot           : one-cycle pulse on space press and on each auto-fire
//   start           : one-cycle pulse on enter press
//   keys_held[9:0]  : {enter, space, right, left, down, up, d, s, a, w}
module ps2_action_mapper #(
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 10_000_000,
  parameter int PREFIX_TIMEOUT = 50_000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic [1:0] mode,
  output logic       forward,
  output logic       backward,
  output logic       rotate_left,
  output logic       rotate_right,
  output logic       shoot,
  output logic       start,
  output logic [9:0] keys_held
);

  // keys_held bit positions
  localparam int K_W     = 0;
  localparam int K_A     = 1;
  localparam int K_S     = 2;
  localparam int K_D     = 3;
  localparam int K_UP    = 4;
  localparam int K_DOWN  = 5;
  localparam int K_LEFT  = 6;
  localparam int K_RIGHT = 7;
  localparam int K_SPACE = 8;
  localparam int K_ENTER = 9;

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER  = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // Map a scan code to its keys_held bit. Plain and extended code spaces
  // are separate: plain 75 and extended 1D hit nothing.
  function automatic logic [9:0] key_mask(input logic ext, input logic [7:0] code);
    logic [9:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h1D:   m[K_W]     = 1'b1;
        8'h1C:   m[K_A]     = 1'b1;
        8'h1B:   m[K_S]     = 1'b1;
        8'h23:   m[K_D]     = 1'b1;
        8'h29:   m[K_SPACE] = 1'b1;
        8'h5A:   m[K_ENTER] = 1'b1;
        default: m          = '0;
      endcase
    end else begin
      case (code)
        8'h75:   m[K_UP]    = 1'b1;
        8'h72:   m[K_DOWN]  = 1'b1;
        8'h6B:   m[K_LEFT]  = 1'b1;
        8'h74:   m[K_RIGHT] = 1'b1;
        default: m          = '0;
      endcase
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------
  // Decoder FSM and held-key table
  // ---------------------------------------------------------------------
  state_t           state, state_n;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n;
  logic [9:0]       set_mask, clr_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      keys_held <= '0;
    end else begin
      state     <= state_n;
      tmo_cnt   <= tmo_cnt_n;
      keys_held <= (keys_held | set_mask) & ~clr_mask;
    end
  end

  always_comb begin
    state_n   = state;
    tmo_cnt_n = tmo_cnt;
    set_mask  = '0;
    clr_mask  = '0;
    if (byte_valid) begin
      // A byte always wins over a coincident timeout.
      tmo_cnt_n = '0;
      case (state)
        S_IDLE: begin
          if (byte_data == B_EXT)      state_n = S_EXT;
          else if (byte_data == B_BRK) state_n = S_BRK;
          else                         set_mask = key_mask(1'b0, byte_data);
        end
        S_EXT: begin
          if (byte_data == B_BRK)      state_n = S_EXT_BRK;
          else if (byte_data == B_EXT) state_n = S_EXT;
          else begin
            set_mask = key_mask(1'b1, byte_data);
            state_n  = S_IDLE;
          end
        end
        S_BRK: begin
          clr_mask = key_mask(1'b0, byte_data);
          state_n  = S_IDLE;
        end
        S_EXT_BRK: begin
          clr_mask = key_mask(1'b1, byte_data);
          state_n  = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      // Abandon a dangling prefix on the PREFIX_TIMEOUT-th idle cycle.
      if (tmo_cnt == TMO_LAST) begin
        state_n   = S_IDLE;
        tmo_cnt_n = '0;
      end else begin
        tmo_cnt_n = tmo_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Action mapping: src = {right, left, backward, forward}
  // ---------------------------------------------------------------------
  logic [3:0] arrow_src, wasd_src, src;

  assign arrow_src = {keys_held[K_RIGHT], keys_held[K_LEFT],
                      keys_held[K_DOWN],  keys_held[K_UP]};
  assign wasd_src  = {keys_held[K_D], keys_held[K_A],
                      keys_held[K_S], keys_held[K_W]};

  always_comb begin
    case (mode)
      2'b00:   src = arrow_src;
      2'b01:   src = wasd_src;
      default: src = arrow_src | wasd_src;
    endcase
  end

  // ---------------------------------------------------------------------
  // Shoot edge detect + auto-fire. rep_cnt counts cycles since the last
  // pulse; rep_first selects the initial delay vs. the steady period.
  // ---------------------------------------------------------------------
  logic             space_d, enter_d;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  logic             rep_first, rep_first_n;
  logic             shoot_n;
  logic             space_press, space_hold;

  assign space_press = keys_held[K_SPACE] & ~space_d;
  assign space_hold  = keys_held[K_SPACE] &  space_d;

  always_comb begin
    shoot_n     = 1'b0;
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
    if (space_press) begin
      shoot_n     = 1'b1;
      rep_cnt_n   = CNT_W'(1);
      rep_first_n = 1'b1;
    end else if (space_hold) begin
      if (rep_cnt == (rep_first ? RPT_DLY : RPT_PER)) begin
        shoot_n     = 1'b1;
        rep_cnt_n   = CNT_W'(1);
        rep_first_n = 1'b0;
      end else begin
        rep_cnt_n = rep_cnt + CNT_W'(1);
      end
    end else begin
      rep_cnt_n   = '0;
      rep_first_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      forward      <= 1'b0;
      backward     <= 1'b0;
      rotate_left  <= 1'b0;
      rotate_right <= 1'b0;
      shoot        <= 1'b0;
      start        <= 1'b0;
      space_d      <= 1'b0;
      enter_d      <= 1'b0;
      rep_cnt      <= '0;
      rep_first    <= 1'b0;
    end else begin
      // Opposing sources held together cancel each other.
      forward      <= src[0] & ~src[1];
      backward     <= src[1] & ~src[0];
      rotate_left  <= src[2] & ~src[3];
      rotate_right <= src[3] & ~src[2];
      shoot        <= shoot_n;
      start        <= keys_held[K_ENTER] & ~enter_d;
      space_d      <= keys_held[K_SPACE];
      enter_d      <= keys_held[K_ENTER];
      rep_cnt      <= rep_cnt_n;
      rep_first    <= rep_first_n;
    end
  end

endmodule

// File: tb/tb_ps2_action_mapper.sv
// Directed bench for ps2_action_mapper. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge of interest.
module tb_ps2_action_mapper;
  localparam int RD = 5;
  localparam int RP = 3;
  localparam int PT = 4;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       forward, backward, rotate_left, rotate_right, shoot, start;
  logic [9:0] keys_held;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_action_mapper #(
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .PREFIX_TIMEOUT(PT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .mode(mode), .forward(forward), .backward(backward),
    .rotate_left(rotate_left), .rotate_right(rotate_right),
    .shoot(shoot), .start(start), .keys_held(keys_held)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte for exactly one rising edge; returns on the next
  // falling edge, where keys_held already reflects it.
  task automatic send(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    got = {keys_held, forward, backward, rotate_left, rotate_right, shoot, start};
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0000", got);
    end
  endtask

  task automatic test_arrow();
    mode = 2'b00;
    send(8'hE0); send(8'h75);
    checks++;
    if (keys_held !== 10'h010) begin failures++; $display("FAIL arrow_keys got=%h exp=010", keys_held); end
    checks++;
    if (forward !== 1'b0) begin failures++; $display("FAIL arrow_latency got=%b exp=0", forward); end
    idle(1);
    checks++;
    if ({forward, backward, rotate_left, rotate_right, shoot, start} !== 6'b100000) begin
      failures++;
      $display("FAIL arrow_press got=%b exp=100000",
               {forward, backward, rotate_left, rotate_right, shoot, start});
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(1);
    checks++;
    if ({keys_held, forward} !== 11'h000) begin
      failures++; $display("FAIL arrow_release got=%h/%b exp=000/0", keys_held, forward);
    end
  endtask

  task automatic test_wasd_mode();
    mode = 2'b01;
    send(8'h1D);
    idle(1);
    checks++;
    if (forward !== 1'b1) begin failures++; $display("FAIL wasd_fwd got=%b exp=1", forward); end
    mode = 2'b00;
    idle(1);
    checks++;
    if (forward !== 1'b0) begin failures++; $display("FAIL mode00_w got=%b exp=0", forward); end
    mode = 2'b01;
    idle(1);
    checks++;
    if (forward !== 1'b1) begin failures++; $display("FAIL mode01_w got=%b exp=1", forward); end
    mode = 2'b11;
    idle(1);
    checks++;
    if (forward !== 1'b1) begin failures++; $display("FAIL mode11_w got=%b exp=1", forward); end
    send(8'hF0); send(8'h1D);
    idle(1);
    checks++;
    if ({keys_held, forward} !== 11'h000) begin
      failures++; $display("FAIL wasd_release got=%h/%b exp=000/0", keys_held, forward);
    end
  endtask

  task automatic test_cancel();
    mode = 2'b10;
    send(8'h1D); send(8'hE0); send(8'h72);
    idle(1);
    checks++;
    if ({keys_held, forward, backward} !== {10'h021, 2'b00}) begin
      failures++; $display("FAIL cancel_fb got=%h/%b%b exp=021/00", keys_held, forward, backward);
    end
    send(8'hF0); send(8'h1D);
    idle(1);
    checks++;
    if ({forward, backward} !== 2'b01) begin
      failures++; $display("FAIL cancel_release got=%b%b exp=01", forward, backward);
    end
    send(8'h1C);
    idle(1);
    checks++;
    if ({rotate_left, rotate_right} !== 2'b10) begin
      failures++; $display("FAIL rot_left got=%b%b exp=10", rotate_left, rotate_right);
    end
    send(8'hE0); send(8'h74);
    idle(1);
    checks++;
    if ({rotate_left, rotate_right} !== 2'b00) begin
      failures++; $display("FAIL cancel_rot got=%b%b exp=00", rotate_left, rotate_right);
    end
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hF0); send(8'h1C);
    idle(1);
    checks++;
    if ({rotate_left, rotate_right, backward} !== 3'b010) begin
      failures++; $display("FAIL cancel_right_only got=%b exp=010",
                           {rotate_left, rotate_right, backward});
    end
    send(8'hE0); send(8'hF0); send(8'h74);
    checks++;
    if (keys_held !== 10'h000) begin failures++; $display("FAIL cancel_cleanup got=%h exp=000", keys_held); end
  endtask

  task automatic test_autofire();
    int pulses;
    logic exp;
    pulses = 0;
    send(8'h29);
    // k indexes rising edges after the press: pulse at 0, 5, 8, 11.
    for (int k = 0; k <= 20; k++) begin
      byte_valid = (k == 1 || k == 5 || k == 12 || k == 13);
      byte_data  = (k == 12) ? 8'hF0 : 8'h29;
      @(negedge clk);
      byte_valid = 1'b0;
      exp = (k == 0 || k == 5 || k == 8 || k == 11);
      if (shoot) pulses++;
      checks++;
      if (shoot !== exp) begin
        failures++; $display("FAIL autofire_k%0d got=%b exp=%b", k, shoot, exp);
      end
    end
    checks++;
    if (pulses !== 4) begin failures++; $display("FAIL autofire_count got=%0d exp=4", pulses); end
    send(8'h29);
    idle(1);
    checks++;
    if (shoot !== 1'b1) begin failures++; $display("FAIL repress got=%b exp=1", shoot); end
    idle(1);
    checks++;
    if (shoot !== 1'b0) begin failures++; $display("FAIL repress_single got=%b exp=0", shoot); end
    send(8'hF0); send(8'h29);
  endtask

  task automatic test_timeout();
    send(8'hE0); idle(PT); send(8'h75);
    checks++;
    if (keys_held !== 10'h000) begin failures++; $display("FAIL tmo_ext got=%h exp=000", keys_held); end
    send(8'h1D);
    send(8'hF0); idle(PT); send(8'h1D);
    checks++;
    if (keys_held !== 10'h001) begin failures++; $display("FAIL tmo_brk got=%h exp=001", keys_held); end
    send(8'hE0); idle(PT - 1); send(8'h75);
    checks++;
    if (keys_held !== 10'h011) begin failures++; $display("FAIL tmo_edge got=%h exp=011", keys_held); end
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h1D);
    send(8'h15); send(8'hE0); send(8'h1D); send(8'h75);
    checks++;
    if (keys_held !== 10'h000) begin failures++; $display("FAIL unknown_codes got=%h exp=000", keys_held); end
  endtask

  task automatic test_reset_mid();
    send(8'hE0);
    do_reset();
    send(8'h1D);
    checks++;
    if (keys_held !== 10'h001) begin failures++; $display("FAIL reset_mid got=%h exp=001", keys_held); end
    do_reset();
    checks++;
    if (keys_held !== 10'h000) begin failures++; $display("FAIL reset_clear got=%h exp=000", keys_held); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      byte_valid = (k < 3);
      byte_data  = 8'h5A;
      @(negedge clk);
      byte_valid = 1'b0;
      if (start) pulses++;
      if (k == 1) begin
        checks++;
        if (start !== 1'b1) begin failures++; $display("FAIL start_pulse got=%b exp=1", start); end
      end
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL start_count got=%0d exp=1", pulses); end
    checks++;
    if (keys_held !== 10'h200) begin failures++; $display("FAIL enter_held got=%h exp=200", keys_held); end
    send(8'hF0); send(8'h5A);
    idle(1);
    checks++;
    if ({keys_held, start} !== 11'h000) begin
      failures++; $display("FAIL enter_release got=%h/%b exp=000/0", keys_held, start);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_arrow();
    test_wasd_mode();
    test_cancel();
    test_autofire();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
